// File: rtl/shift_rx_arbiter.sv
// Round-robin scheduler for two serial sources sharing one
// serial-in shift register, with a valid/ready word output.
module shift_rx_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             sin0,
  input  logic             sin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    VALID
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic             sel_q;
  logic             rr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sr_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             busy_q;
  logic             valid_q;

  logic sin_sel;
  logic pick;

  assign sin_sel = sel_q ? sin1 : sin0;
  // Contention goes to the pointer; otherwise the lone requester wins
  assign pick = (req0 && req1) ? rr_q : req1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q <= SHIFT;
            sel_q   <= pick;
            cnt_q   <= '0;
            gnt0_q  <= ~pick;
            gnt1_q  <= pick;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          sr_q  <= {sin_sel, sr_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= VALID;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        VALID: begin
          if (out_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            rr_q    <= ~sel_q;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign out_data  = sr_q;

endmodule

// File: tb/tb_shift_rx_arbiter.sv
// Bench for shift_rx_arbiter: vector table, directed corners,
// and random traffic against a transaction-level model.
module tb_shift_rx_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 0, req1 = 0, sin0 = 0, sin1 = 0, rdy = 0;
  logic       gnt0, gnt1, busy, valid;
  logic [3:0] data;

  logic       w_req0 = 0, w_req1 = 0, w_sin0 = 0, w_sin1 = 0, w_rdy = 0;
  logic       w_gnt0, w_gnt1, w_busy, w_valid;
  logic [7:0] w_data;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  shift_rx_arbiter #(.WIDTH(4), .CNT_W(2)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .sin0(sin0), .sin1(sin1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .out_data(data), .out_valid(valid),
    .out_ready(rdy)
  );

  shift_rx_arbiter #(.WIDTH(8), .CNT_W(3)) dut8 (
    .clock(clock), .reset(reset),
    .req0(w_req0), .req1(w_req1),
    .sin0(w_sin0), .sin1(w_sin1),
    .gnt0(w_gnt0), .gnt1(w_gnt1), .busy(w_busy),
    .out_data(w_data), .out_valid(w_valid),
    .out_ready(w_rdy)
  );

  typedef struct {
    logic       r0, r1, s0, s1, rd;
    logic       g0, g1, v, b;
    logic [3:0] d;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    req0 = 0; req1 = 0; rdy = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(logic r0, logic s0, logic rd, logic g0,
                              logic v, logic b, logic [3:0] d);
    vec_t x;
    x.r0 = r0; x.r1 = 1'b0; x.s0 = s0; x.s1 = 1'b0; x.rd = rd;
    x.g0 = g0; x.g1 = 1'b0; x.v = v; x.b = b; x.d = d;
    return x;
  endfunction

  // transaction-level reference state
  int         m_phase, m_owner, m_prio, m_data;
  logic [3:0] q_words[$];

  initial begin
    // single word, then the same word under backpressure
    vt[0]  = mk(1, 0, 1, 1, 0, 1, 4'b0000);
    vt[1]  = mk(0, 1, 1, 1, 0, 1, 4'b1000);
    vt[2]  = mk(0, 0, 1, 1, 0, 1, 4'b0100);
    vt[3]  = mk(0, 1, 1, 1, 0, 1, 4'b1010);
    vt[4]  = mk(0, 1, 1, 0, 1, 1, 4'b1101);
    vt[5]  = mk(0, 0, 1, 0, 0, 0, 4'b1101);
    vt[6]  = mk(0, 0, 1, 0, 0, 0, 4'b1101);
    vt[7]  = mk(1, 0, 0, 1, 0, 1, 4'b1101);
    vt[8]  = mk(0, 1, 0, 1, 0, 1, 4'b1110);
    vt[9]  = mk(0, 0, 0, 1, 0, 1, 4'b0111);
    vt[10] = mk(0, 1, 0, 1, 0, 1, 4'b1011);
    vt[11] = mk(0, 1, 0, 0, 1, 1, 4'b1101);
    for (int i = 12; i < 18; i++)
      vt[i] = mk(0, logic'(i % 2), 0, 0, 1, 1, 4'b1101);
    vt[18] = mk(0, 1, 1, 0, 0, 0, 4'b1101);
    vt[19] = mk(0, 0, 1, 0, 0, 0, 4'b1101);

    #2;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", {7'd0, valid}, 8'd0);
      chk("idle_gnt", {6'd0, gnt1, gnt0}, 8'd0);
      chk("idle_busy", {7'd0, busy}, 8'd0);
      chk("idle_data", {4'd0, data}, 8'd0);
    end

    foreach (vt[i]) begin
      req0 = vt[i].r0; req1 = vt[i].r1;
      sin0 = vt[i].s0; sin1 = vt[i].s1; rdy = vt[i].rd;
      tick();
      chk($sformatf("vec%0d_gnt0", i), {7'd0, gnt0}, {7'd0, vt[i].g0});
      chk($sformatf("vec%0d_gnt1", i), {7'd0, gnt1}, {7'd0, vt[i].g1});
      chk($sformatf("vec%0d_valid", i), {7'd0, valid}, {7'd0, vt[i].v});
      chk($sformatf("vec%0d_busy", i), {7'd0, busy}, {7'd0, vt[i].b});
      chk($sformatf("vec%0d_data", i), {4'd0, data}, {4'd0, vt[i].d});
    end

    // both requesters held: words must alternate starting with 0
    do_reset();
    req0 = 1; req1 = 1; sin0 = 1; sin1 = 0; rdy = 1;
    q_words.delete();
    for (int c = 0; c < 30; c++) begin
      tick();
      chk("arb_excl", {7'd0, gnt0 & gnt1}, 8'd0);
      if (valid) q_words.push_back(data);
    end
    chk("arb_count", {7'd0, q_words.size() >= 4}, 8'd1);
    for (int k = 0; k < 4 && k < q_words.size(); k++)
      chk($sformatf("arb_word%0d", k), {4'd0, q_words[k]},
          (k % 2 == 0) ? 8'h0f : 8'h00);

    // async reset in the middle of a word
    do_reset();
    req0 = 1; sin0 = 1; rdy = 1;
    tick();
    req0 = 0;
    tick();
    tick();
    chk("mid_gnt_before", {7'd0, gnt0}, 8'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_gnt", {6'd0, gnt1, gnt0}, 8'd0);
    chk("mid_busy", {7'd0, busy}, 8'd0);
    chk("mid_valid", {7'd0, valid}, 8'd0);
    chk("mid_data", {4'd0, data}, 8'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("post_rst_valid", {7'd0, valid | busy}, 8'd0);
    end
    req1 = 1;
    tick();
    chk("fresh_gnt1", {7'd0, gnt1}, 8'd1);
    req1 = 0;
    begin
      logic [3:0] bits;
      bits = 4'b0110;
      for (int k = 0; k < 4; k++) begin
        sin1 = bits[k];
        tick();
      end
    end
    chk("fresh_valid", {7'd0, valid}, 8'd1);
    chk("fresh_data", {4'd0, data}, 8'h06);
    tick();
    chk("fresh_done", {7'd0, valid | busy}, 8'd0);

    // 8-bit instance: one word from requester 1
    begin
      logic [7:0] bits;
      int ng;
      bits = 8'b1000_0001;
      ng = 0;
      w_req1 = 1; w_rdy = 0;
      tick();
      w_req1 = 0;
      if (w_gnt1) ng++;
      for (int k = 0; k < 8; k++) begin
        chk("w8_valid_early", {7'd0, w_valid}, 8'd0);
        w_sin1 = bits[k];
        tick();
        if (w_gnt1) ng++;
      end
      chk("w8_gnt_cycles", 8'(ng), 8'd8);
      chk("w8_valid", {7'd0, w_valid}, 8'd1);
      chk("w8_data", w_data, 8'h81);
      w_rdy = 1;
      tick();
      chk("w8_done", {7'd0, w_valid}, 8'd0);
    end

    // random traffic against the reference model
    do_reset();
    m_phase = 0; m_owner = 0; m_prio = 0; m_data = 0;
    for (int c = 0; c < 400; c++) begin
      req0 = logic'($urandom_range(0, 1));
      req1 = logic'($urandom_range(0, 1));
      sin0 = logic'($urandom_range(0, 1));
      sin1 = logic'($urandom_range(0, 1));
      rdy  = ($urandom_range(0, 9) < 6);
      if (m_phase == 0) begin
        if (req0 || req1) begin
          m_owner = (req0 && req1) ? m_prio : (req1 ? 1 : 0);
          m_phase = 1;
        end
      end else if (m_phase <= 4) begin
        m_data = (m_data / 2) + ((m_owner == 1 ? int'(sin1) : int'(sin0)) * 8);
        m_phase++;
      end else if (rdy) begin
        m_phase = 0;
        m_prio = 1 - m_owner;
      end
      tick();
      chk("rnd_gnt0", {7'd0, gnt0},
          {7'd0, m_phase >= 1 && m_phase <= 4 && m_owner == 0});
      chk("rnd_gnt1", {7'd0, gnt1},
          {7'd0, m_phase >= 1 && m_phase <= 4 && m_owner == 1});
      chk("rnd_busy", {7'd0, busy}, {7'd0, m_phase != 0});
      chk("rnd_valid", {7'd0, valid}, {7'd0, m_phase == 5});
      chk("rnd_data", {4'd0, data}, 8'(m_data));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
